// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot loader that streams a checksummed image into instruction memory, then releases the core
// ports: i_clk/i_rst (sync, active-high); i_byte_valid/i_byte/o_byte_ready byte handshake;
//        o_we/o_addr/o_wdata memory write port; o_core_rst_n core reset (low = held);
//        o_done sticky load success; o_err sticky load failure
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_core_rst_n,
  output logic              o_done,
  output logic              o_err
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  state_t state;
  logic [15:0] n;
  logic [16:0] wcnt;
  logic [1:0] bidx;
  logic [7:0] csum;
  logic [23:0] shift;
  logic xfer;
  logic [15:0] n_full;
  assign xfer = i_byte_valid && o_byte_ready;
  assign n_full = {n[15:8], i_byte};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= HDR0;
      n <= '0;
      wcnt <= '0;
      bidx <= '0;
      csum <= '0;
      shift <= '0;
      o_byte_ready <= 1'b0;
      o_we <= 1'b0;
      o_addr <= BASE_ADDR;
      o_wdata <= '0;
      o_core_rst_n <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_we <= 1'b0;
      case (state)
        HDR0: begin
          // ready rises here the first cycle out of reset and stays up until a terminal state
          o_byte_ready <= 1'b1;
          if (xfer) begin
            n[15:8] <= i_byte;
            state <= HDR1;
          end
        end
        HDR1: if (xfer) begin
          n <= n_full;
          if ({1'b0, n_full} > CAP) begin
            state <= ERR;
            o_err <= 1'b1;
            o_byte_ready <= 1'b0;
          end else begin
            state <= (n_full == 16'd0) ? CSUM : DATA;
          end
        end
        DATA: if (xfer) begin
          shift <= {shift[15:0], i_byte};
          csum <= csum ^ i_byte;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            o_wdata <= {shift, i_byte};
            o_addr <= BASE_ADDR + wcnt[ADDR_W-1:0];
            o_we <= 1'b1;
            wcnt <= wcnt + 17'd1;
            if (wcnt + 17'd1 == {1'b0, n}) state <= CSUM;
          end
        end
        CSUM: if (xfer) begin
          o_byte_ready <= 1'b0;
          if (i_byte == csum) begin
            state <= DONE;
            o_done <= 1'b1;
            o_core_rst_n <= 1'b1;
          end else begin
            state <= ERR;
            o_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: table-driven image loads with a write scoreboard on two base addresses
module tb_instr_mem_loader;
  logic i_clk = 0, i_rst = 1, i_byte_valid = 0;
  logic [7:0] i_byte = 0;
  logic rdy0, we0, crst0, done0, err0, rdy1, we1, crst1, done1, err1;
  logic [9:0] addr0, addr1;
  logic [31:0] wd0, wd1;
  int checks = 0, errors = 0;
  logic [41:0] q0[$], q1[$];
  typedef struct {
    string name;
    int n;
    bit bad;
    bit thr;
    bit exp_done;
  } vec_t;
  vec_t vecs[7];

  always #5 i_clk = ~i_clk;

  instr_mem_loader dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(rdy0), .o_we(we0), .o_addr(addr0), .o_wdata(wd0),
    .o_core_rst_n(crst0), .o_done(done0), .o_err(err0));

  instr_mem_loader #(.ADDR_W(10), .BASE_ADDR(10'h3FF)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(rdy1), .o_we(we1), .o_addr(addr1), .o_wdata(wd1),
    .o_core_rst_n(crst1), .o_done(done1), .o_err(err1));

  task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) if (we0) begin
    if (q0.size() == 0) chk("wr0_unexpected", {addr0, wd0}, 42'h0);
    else chk("wr0", {addr0, wd0}, q0.pop_front());
  end

  always @(negedge i_clk) if (we1) begin
    if (q1.size() == 0) chk("wr1_unexpected", {addr1, wd1}, 42'h0);
    else chk("wr1", {addr1, wd1}, q1.pop_front());
  end

  function automatic logic [31:0] word_of(int i);
    return i == 0 ? 32'hDEADBEEF : i == 1 ? 32'h01234567 : 32'h9E3779B9 * 32'(i);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int t = 0;
    if (thr) begin
      i_byte_valid = 0;
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    i_byte_valid = 1;
    i_byte = b;
    while (!rdy0 && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (!rdy0) begin
      chk("ready_timeout", 42'(rdy0), 42'h1);
      i_byte_valid = 0;
      return;
    end
    @(negedge i_clk);
    i_byte_valid = 0;
  endtask

  task automatic do_reset();
    i_rst = 1;
    i_byte_valid = 0;
    @(negedge i_clk);
    q0.delete();
    q1.delete();
    chk("rst_ready", 42'(rdy0), 42'h0);
    chk("rst_we", 42'(we0 | we1), 42'h0);
    chk("rst_addr0", 42'(addr0), 42'h0);
    chk("rst_addr1", 42'(addr1), 42'h3FF);
    chk("rst_wdata", 42'(wd0), 42'h0);
    chk("rst_status", {39'h0, crst0, done0, err0}, 42'h0);
    i_rst = 0;
    @(negedge i_clk);
    chk("ready_after_rst", 42'(rdy0 & rdy1), 42'h1);
  endtask

  task automatic run_vec(input vec_t v, input bit rst_first);
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0] cs, b;
    nn = 16'(v.n);
    cs = 0;
    if (rst_first) do_reset();
    send_byte(nn[15:8], v.thr);
    send_byte(nn[7:0], v.thr);
    if (nn <= 16'd1024) begin
      for (int i = 0; i < v.n; i++) begin
        w = word_of(i);
        for (int k = 0; k < 4; k++) begin
          b = w[31-8*k -: 8];
          cs ^= b;
          if (k == 3) begin
            q0.push_back({10'(i), w});
            q1.push_back({10'h3FF + 10'(i), w});
          end
          send_byte(b, v.thr);
        end
      end
      send_byte(v.bad ? ~cs : cs, v.thr);
    end
    repeat (2) @(negedge i_clk);
    chk({v.name, "_done"}, 42'(done0 & done1), 42'(v.exp_done));
    chk({v.name, "_err"}, 42'(err0 | err1), 42'(!v.exp_done));
    chk({v.name, "_core_rst_n"}, 42'(crst0 | crst1), 42'(v.exp_done));
    chk({v.name, "_ready"}, 42'(rdy0 | rdy1), 42'h0);
    chk({v.name, "_writes_left"}, 42'(q0.size() + q1.size()), 42'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"basic", 2, 0, 0, 1};
    vecs[1] = '{"bad_csum", 2, 1, 0, 0};
    vecs[2] = '{"throttled", 2, 0, 1, 1};
    vecs[3] = '{"too_long", 1025, 0, 0, 0};
    vecs[4] = '{"empty", 0, 0, 0, 1};
    vecs[5] = '{"five_thr", 5, 0, 1, 1};
    vecs[6] = '{"full", 1024, 0, 0, 1};
    @(negedge i_clk);
    foreach (vecs[i]) run_vec(vecs[i], 1);
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    i_rst = 1;
    i_byte_valid = 1;
    i_byte = 8'hEF;
    @(negedge i_clk);
    chk("midrst_we", 42'(we0 | we1), 42'h0);
    chk("midrst_core_rst_n", 42'(crst0 | crst1), 42'h0);
    chk("midrst_ready", 42'(rdy0), 42'h0);
    i_rst = 0;
    i_byte_valid = 0;
    @(negedge i_clk);
    chk("midrst_ready_back", 42'(rdy0), 42'h1);
    run_vec(vecs[0], 0);
    i_byte_valid = 1;
    i_byte = 8'h55;
    repeat (3) @(negedge i_clk);
    i_byte_valid = 0;
    chk("done_holds", {40'h0, done0, err0}, 42'h2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
